dmx_frame_controller: RTL and testbench



---
 rtl/dmx_pkg.sv | 28 ++
 rtl/dmx_line_timer.sv | 54 +++++
 rtl/dmx_frame_controller.sv | 167 ++++++++++++++++
 tb/tb_dmx_frame_controller.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmx_pkg.sv
// ============================================================================
// Module      : dmx_pkg
// Description : Shared DMX512 frame-controller types, constants and the
//               microsecond-to-cycle conversion used for line timing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmx_pkg;

    localparam int         DMX_MAX_SLOTS   = 512;
    localparam logic [7:0] START_CODE_NULL = 8'h00;

    typedef enum logic [2:0] {
        HUNT    = 3'd0,
        BREAK   = 3'd1,
        MAB     = 3'd2,
        WAIT_SC = 3'd3,
        RECEIVE = 3'd4
    } dmx_state_e;

    function automatic int us_to_cycles(input longint clk_freq, input longint us);
        return int'((clk_freq * us) / 64'd1_000_000);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmx_line_timer.sv
// ============================================================================
// Module      : dmx_line_timer
// Description : 2-FF synchroniser for the DMX line plus saturating low/high
//               run-length counters that flag BREAK and MAB durations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmx_line_timer #(
    parameter int BREAK_CYC = 1760,
    parameter int MAB_CYC   = 160
) (
    input  logic clk,
    input  logic rst_n,
    input  logic dmx_in,
    output logic dmx_sync,
    output logic break_seen,
    output logic mab_seen
);

    localparam int LW = $clog2(BREAK_CYC + 1);
    localparam int HW = $clog2(MAB_CYC + 1);

    logic [1:0]    r_sync;
    logic [LW-1:0] r_low_cnt;
    logic [HW-1:0] r_high_cnt;

    // Counters run on the synchronised line so they agree with what the FSM sees
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync     <= 2'b11;
            r_low_cnt  <= '0;
            r_high_cnt <= '0;
        end else begin
            r_sync <= {r_sync[0], dmx_in};
            if (r_sync[1]) begin
                r_low_cnt <= '0;
                if (r_high_cnt != HW'(MAB_CYC))
                    r_high_cnt <= r_high_cnt + HW'(1);
            end else begin
                r_high_cnt <= '0;
                if (r_low_cnt != LW'(BREAK_CYC))
                    r_low_cnt <= r_low_cnt + LW'(1);
            end
        end
    end

    assign dmx_sync   = r_sync[1];
    assign break_seen = (r_low_cnt == LW'(BREAK_CYC));
    assign mab_seen   = (r_high_cnt == HW'(MAB_CYC));

endmodule

`default_nettype wire

// File: rtl/dmx_frame_controller.sv
// ============================================================================
// Module      : dmx_frame_controller
// Description : DMX512 frame sequencer: BREAK/MAB detection, receiver start
//               trigger, slot counting and channel-window buffer writes.
//               Optional macro DMX_ALT_START_CODE_EN accepts any start code.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmx_frame_controller #(
    parameter  int CLK_FREQ     = 20_000_000,
    parameter  int NUM_CH       = 16,
    parameter  int BREAK_MIN_US = 88,
    parameter  int MAB_MIN_US   = 8,
    localparam int ADDR_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dmx_in,
    output logic              dmx_sync,
    output logic              start_receive,
    input  logic              rx_byte_ready,
    input  logic [7:0]        rx_byte,
    input  logic              rx_error,
    input  logic              rx_byte_done,
    input  logic [8:0]        base_addr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [7:0]        start_code,
    output logic [9:0]        slot_count,
    output logic              frame_done,
    output logic              frame_ok
);

    import dmx_pkg::*;

    localparam int BREAK_CYC = us_to_cycles(CLK_FREQ, BREAK_MIN_US);
    localparam int MAB_CYC   = us_to_cycles(CLK_FREQ, MAB_MIN_US);

    dmx_state_e r_state;
    logic       r_sc_pending;
    logic [9:0] r_base;
    logic [9:0] r_slot_cnt;

    logic       w_break_seen;
    logic       w_mab_seen;
    logic       w_sc_ok;
    logic       w_count_byte;
    logic       w_in_win;
    logic [9:0] w_slot_next;
    logic [9:0] w_slot_total;
    logic [9:0] w_off;

    dmx_line_timer #(
        .BREAK_CYC (BREAK_CYC),
        .MAB_CYC   (MAB_CYC)
    ) u_line_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .dmx_in     (dmx_in),
        .dmx_sync   (dmx_sync),
        .break_seen (w_break_seen),
        .mab_seen   (w_mab_seen)
    );

`ifdef DMX_ALT_START_CODE_EN
    assign w_sc_ok = 1'b1;
`else
    assign w_sc_ok = (rx_byte == START_CODE_NULL);
`endif

    // Offset form of the window test keeps the upper bound from wrapping in 10 bits
    assign w_slot_next  = r_slot_cnt + 10'd1;
    assign w_off        = w_slot_next - r_base;
    assign w_in_win     = (w_slot_next >= r_base) && (w_off < 10'(NUM_CH));
    assign w_count_byte = rx_byte_ready && !r_sc_pending
                          && (r_slot_cnt != 10'(DMX_MAX_SLOTS));
    assign w_slot_total = w_count_byte ? w_slot_next : r_slot_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= HUNT;
            r_sc_pending  <= 1'b0;
            r_base        <= 10'd1;
            r_slot_cnt    <= '0;
            start_receive <= 1'b0;
            wr_en         <= 1'b0;
            wr_addr       <= '0;
            wr_data       <= '0;
            start_code    <= '0;
            slot_count    <= '0;
            frame_done    <= 1'b0;
            frame_ok      <= 1'b0;
        end else begin
            start_receive <= 1'b0;
            wr_en         <= 1'b0;
            frame_done    <= 1'b0;
            frame_ok      <= 1'b0;
            case (r_state)
                HUNT: begin
                    if (w_break_seen)
                        r_state <= BREAK;
                end
                BREAK: begin
                    if (dmx_sync)
                        r_state <= MAB;
                end
                MAB: begin
                    if (w_mab_seen) begin
                        r_state      <= WAIT_SC;
                        r_base       <= (base_addr == 9'd0) ? 10'd1 : {1'b0, base_addr};
                        r_slot_cnt   <= '0;
                        r_sc_pending <= 1'b1;
                    end else if (!dmx_sync) begin
                        r_state <= HUNT;
                    end
                end
                WAIT_SC: begin
                    if (!dmx_sync) begin
                        start_receive <= 1'b1;
                        r_state       <= RECEIVE;
                    end
                end
                RECEIVE: begin
                    if (rx_byte_ready && r_sc_pending && !w_sc_ok) begin
                        start_code   <= rx_byte;
                        r_sc_pending <= 1'b0;
                        r_state      <= HUNT;
                    end else begin
                        if (rx_byte_ready && r_sc_pending) begin
                            start_code   <= rx_byte;
                            r_sc_pending <= 1'b0;
                        end
                        if (w_count_byte) begin
                            r_slot_cnt <= w_slot_next;
                            if (w_in_win) begin
                                wr_en   <= 1'b1;
                                wr_addr <= w_off[ADDR_W-1:0];
                                wr_data <= rx_byte;
                            end
                        end
                        // Error outranks the timeout; a byte in the same cycle is already counted
                        if (rx_error) begin
                            frame_done <= 1'b1;
                            slot_count <= w_slot_total;
                            r_state    <= HUNT;
                        end else if (rx_byte_done) begin
                            frame_done <= 1'b1;
                            frame_ok   <= 1'b1;
                            slot_count <= w_slot_total;
                            r_state    <= HUNT;
                        end else if (w_break_seen) begin
                            frame_done <= 1'b1;
                            slot_count <= w_slot_total;
                            r_state    <= BREAK;
                        end
                    end
                end
                default: r_state <= HUNT;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dmx_frame_controller.sv
// ============================================================================
// Module      : tb_dmx_frame_controller
// Description : Randomised frame-level bench for dmx_frame_controller with an
//               emulated byte receiver and a slot-window reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_dmx_frame_controller;

    localparam int CLK_FREQ     = 1_000_000;
    localparam int NUM_CH       = 16;
    localparam int BREAK_MIN_US = 88;
    localparam int MAB_MIN_US   = 8;
    localparam int CYC_PER_US   = CLK_FREQ / 1_000_000;
    localparam int AW           = 4;
`ifdef DMX_ALT_START_CODE_EN
    localparam bit ALT_SC = 1'b1;
`else
    localparam bit ALT_SC = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          dmx_in = 1'b1;
    logic          dmx_sync;
    logic          start_receive;
    logic          rx_byte_ready = 1'b0;
    logic [7:0]    rx_byte = 8'h00;
    logic          rx_error = 1'b0;
    logic          rx_byte_done = 1'b0;
    logic [8:0]    base_addr = 9'd1;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic [7:0]    start_code;
    logic [9:0]    slot_count;
    logic          frame_done;
    logic          frame_ok;

    dmx_frame_controller #(
        .CLK_FREQ     (CLK_FREQ),
        .NUM_CH       (NUM_CH),
        .BREAK_MIN_US (BREAK_MIN_US),
        .MAB_MIN_US   (MAB_MIN_US)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .dmx_in        (dmx_in),
        .dmx_sync      (dmx_sync),
        .start_receive (start_receive),
        .rx_byte_ready (rx_byte_ready),
        .rx_byte       (rx_byte),
        .rx_error      (rx_error),
        .rx_byte_done  (rx_byte_done),
        .base_addr     (base_addr),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .start_code    (start_code),
        .slot_count    (slot_count),
        .frame_done    (frame_done),
        .frame_ok      (frame_ok)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int exp_sc   = 0;
    int exp_slot_reg = 0;

    int mon_sr = 0;
    int mon_fd = 0;
    int mon_fd_ok = 0;
    int mon_fd_slots = 0;
    int mon_wa[$];
    int mon_wd[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (start_receive) mon_sr++;
            if (wr_en) begin
                mon_wa.push_back(int'(wr_addr));
                mon_wd.push_back(int'(wr_data));
            end
            if (frame_done) begin
                mon_fd++;
                mon_fd_ok    = int'(frame_ok);
                mon_fd_slots = int'(slot_count);
            end
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rx_pulse(input bit rdy, input bit err, input bit done, input logic [7:0] b);
        rx_byte_ready = rdy;
        rx_error      = err;
        rx_byte_done  = done;
        rx_byte       = b;
        step(1);
        rx_byte_ready = 1'b0;
        rx_error      = 1'b0;
        rx_byte_done  = 1'b0;
        step(2);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_dmx_sync"}, int'(dmx_sync), 1);
        chk({tag, "_start_receive"}, int'(start_receive), 0);
        chk({tag, "_wr_en"}, int'(wr_en), 0);
        chk({tag, "_wr_addr"}, int'(wr_addr), 0);
        chk({tag, "_wr_data"}, int'(wr_data), 0);
        chk({tag, "_start_code"}, int'(start_code), 0);
        chk({tag, "_slot_count"}, int'(slot_count), 0);
        chk({tag, "_frame_done"}, int'(frame_done), 0);
        chk({tag, "_frame_ok"}, int'(frame_ok), 0);
    endtask

    // One frame on the line plus the receiver's strobes; err_slot 0 means a clean end
    task automatic run_frame(input int brk_us, input int mab_us, input int sc, input int nslots,
                             input int base, input int err_slot, input bit err_byte, input bit rnd);
        int  d[$];
        int  exp_wa[$];
        int  exp_wd[$];
        int  wa0, sr0, fd0, eb, processed, exp_slots, nw;
        bit  timing_ok, accepted, clean;
        wa0 = mon_wa.size();
        sr0 = mon_sr;
        fd0 = mon_fd;
        for (int i = 1; i <= nslots; i++)
            d.push_back(rnd ? int'($urandom_range(0, 255)) : (i & 255));
        base_addr = 9'(base);
        dmx_in = 1'b0; step(brk_us * CYC_PER_US);
        dmx_in = 1'b1; step(mab_us * CYC_PER_US);
        dmx_in = 1'b0; step(4);
        dmx_in = 1'b1; step(6);
        rx_pulse(1'b1, 1'b0, 1'b0, 8'(sc));
        for (int i = 1; i <= nslots; i++) begin
            if (i == err_slot) begin
                rx_pulse(err_byte, 1'b1, 1'b0, 8'(d[i-1]));
                break;
            end
            rx_pulse(1'b1, 1'b0, 1'b0, 8'(d[i-1]));
        end
        clean = (err_slot < 1) || (err_slot > nslots);
        if (clean) rx_pulse(1'b0, 1'b0, 1'b1, 8'h00);
        step(5);

        timing_ok = (brk_us >= BREAK_MIN_US) && (mab_us >= MAB_MIN_US);
        accepted  = timing_ok && ((sc == 0) || ALT_SC);
        eb        = (base == 0) ? 1 : base;
        processed = clean ? nslots : (err_byte ? err_slot : err_slot - 1);
        exp_slots = (processed > 512) ? 512 : processed;
        if (timing_ok) exp_sc = sc;
        if (accepted) begin
            exp_slot_reg = exp_slots;
            for (int n = 1; n <= exp_slots; n++)
                if (n >= eb && n < eb + NUM_CH) begin
                    exp_wa.push_back(n - eb);
                    exp_wd.push_back(d[n-1]);
                end
        end

        chk("start_receive_cnt", mon_sr - sr0, int'(timing_ok));
        chk("frame_done_cnt", mon_fd - fd0, int'(accepted));
        if (accepted) begin
            chk("frame_ok", mon_fd_ok, int'(clean));
            chk("fd_slot_count", mon_fd_slots, exp_slots);
        end
        nw = mon_wa.size() - wa0;
        chk("wr_count", nw, exp_wa.size());
        for (int i = 0; i < nw && i < exp_wa.size(); i++) begin
            chk("wr_addr", mon_wa[wa0 + i], exp_wa[i]);
            chk("wr_data", mon_wd[wa0 + i], exp_wd[i]);
        end
        chk("start_code", int'(start_code), exp_sc);
        chk("slot_count", int'(slot_count), exp_slot_reg);
    endtask

    initial begin
        int fd0;
        rst_n = 1'b0;
        step(3);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        step(5);

        run_frame(100, 12, 0, 20, 5, 0, 1'b0, 1'b0);
        run_frame(80, 12, 0, 10, 1, 0, 1'b0, 1'b1);
        run_frame(88, 12, 0, 10, 1, 0, 1'b0, 1'b1);
        run_frame(100, 4, 0, 10, 1, 0, 1'b0, 1'b1);
        run_frame(88, 12, 0, 18, 2, 0, 1'b0, 1'b1);
        run_frame(100, 12, 8'hCC, 20, 1, 0, 1'b0, 1'b1);
        run_frame(100, 12, 0, 20, 1, 7, 1'b0, 1'b1);
        run_frame(88, 12, 0, 20, 3, 0, 1'b0, 1'b1);
        run_frame(87, 12, 0, 8, 1, 0, 1'b0, 1'b1);
        run_frame(100, 7, 0, 8, 1, 0, 1'b0, 1'b1);
        run_frame(100, 8, 0, 8, 1, 0, 1'b0, 1'b1);
        run_frame(100, 12, 0, 20, 1, 9, 1'b1, 1'b1);
        run_frame(100, 12, 0, 515, 510, 0, 1'b0, 1'b1);
        run_frame(100, 12, 0, 20, 0, 0, 1'b0, 1'b1);

        for (int k = 0; k < 16; k++) begin
            int brk, mab, sc, ns, base, es;
            brk  = int'($urandom_range(80, 130));
            mab  = int'($urandom_range(3, 16));
            sc   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 255)) : 0;
            ns   = int'($urandom_range(1, 40));
            base = int'($urandom_range(0, 30));
            es   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, ns)) : 0;
            run_frame(brk, mab, sc, ns, base, es, 1'($urandom_range(0, 1)), 1'b1);
        end

        // Reset in the middle of a frame must not produce a frame_done
        base_addr = 9'd1;
        dmx_in = 1'b0; step(100);
        dmx_in = 1'b1; step(12);
        dmx_in = 1'b0; step(4);
        dmx_in = 1'b1; step(6);
        rx_pulse(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) rx_pulse(1'b1, 1'b0, 1'b0, 8'(i + 100));
        fd0 = mon_fd;
        rst_n = 1'b0;
        step(3);
        check_reset_outputs("midreset");
        rx_pulse(1'b0, 1'b0, 1'b1, 8'h00);
        rst_n = 1'b1;
        step(3);
        chk("midreset_no_done", mon_fd - fd0, 0);
        exp_sc = 0;
        exp_slot_reg = 0;
        run_frame(100, 12, 0, 24, 9, 0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
